core_mem_nport: RTL

- Parametrised successor to the 4-port 16K core memory module.
- N-port, 36-bit-word memory bank on the processor memory bus.
- Arbitrates cycle requests round-robin and runs read-restore, clear-write and read-pause-write cycles against an inferred RAM.
- Timing is set in clock counts; supports single-step stop and key restart.

---
 rtl/core_mem_nport_if.sv | 28 ++
 rtl/core_mem_nport.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/core_mem_nport_if.sv
// Processor memory bus bundle for core_mem_nport; every field is a per-port packed vector.
// The master drives requests and write data, the slave (memory bank) drives acks and read data.
interface core_mem_nport_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned AW    = 14
);
  logic [NPORT-1:0]      rq_cyc;
  logic [NPORT-1:0]      rd_rq;
  logic [NPORT-1:0]      wr_rq;
  logic [NPORT-1:0]      wr_rs;
  logic [NPORT-1:0]      fmc_select;
  logic [4*NPORT-1:0]    sel;
  logic [AW*NPORT-1:0]   ma;
  logic [36*NPORT-1:0]   mb_in;
  logic [NPORT-1:0]      addr_ack;
  logic [NPORT-1:0]      rd_rs;
  logic [36*NPORT-1:0]   mb_out;

  modport master (
    output rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, sel, ma, mb_in,
    input  addr_ack, rd_rs, mb_out
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, sel, ma, mb_in,
    output addr_ack, rd_rs, mb_out
  );
endinterface

// File: rtl/core_mem_nport.sv
// N-port 36-bit core memory bank: round-robin arbitration, read-restore / read-pause-write cycles.
// Optional parity: define CORE_PARITY_EN for a 37-bit RAM and a parity_err output.
module core_mem_nport #(
  parameter int unsigned        NPORT   = 4,
  parameter int unsigned        AW      = 14,
  parameter logic [4*NPORT-1:0] MEMSEL  = '0,
  parameter int unsigned        T_READ  = 6,
  parameter int unsigned        T_WRITE = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sw_single_step,
  input  logic            sw_restart,
  core_mem_nport_if.slave membus,
  output logic            stopped,
  output logic            busy
`ifdef CORE_PARITY_EN
  ,
  output logic            parity_err
`endif
);
  localparam int unsigned PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned TMAX = (T_READ > T_WRITE) ? T_READ : T_WRITE;
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
`ifdef CORE_PARITY_EN
  localparam int unsigned MW = 37;
`else
  localparam int unsigned MW = 36;
`endif

  typedef enum logic [2:0] {
    StIdle, StAck, StRead, StPause, StWrite, StRecover, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, port_q, port_d, gnt_port, idx;
  logic [AW-1:0]   cma_q, cma_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [35:0]     cmb_q, cmb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            restart_q;
  logic [NPORT-1:0] qual;
  logic            gnt_valid, strobe, wr_en;
  logic [MW-1:0]   mem [2**AW];
  logic [MW-1:0]   rdata_q, wdata;

  always_comb begin
    qual = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      qual[i] = membus.rq_cyc[i] & (membus.sel[4*i +: 4] == MEMSEL[4*i +: 4])
                & ~membus.fmc_select[i];
    end
  end

  // Scan downward so the nearest qualified port after the pointer wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = '0;
    idx       = '0;
    for (int k = int'(NPORT); k >= 1; k--) begin
      idx = PW'((32'(ptr_q) + 32'(k)) % NPORT);
      if (qual[idx]) begin
        gnt_valid = 1'b1;
        gnt_port  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    cma_d   = cma_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cmb_d   = cmb_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          port_d  = gnt_port;
          ptr_d   = gnt_port;
          cma_d   = membus.ma[32'(gnt_port)*AW +: AW];
          rd_d    = membus.rd_rq[gnt_port];
          wr_d    = membus.wr_rq[gnt_port];
          cmb_d   = '0;
          cnt_d   = '0;
          state_d = StAck;
        end
      end
      StAck: begin
        cnt_d   = '0;
        state_d = StRead;
      end
      StRead: begin
        if (cnt_q == CW'(T_READ - 1)) begin
          strobe = 1'b1;
          // A pure write cycle clears the word; everything else restores it.
          if (!(wr_q && !rd_q)) cmb_d = rdata_q[35:0];
          cnt_d   = '0;
          state_d = wr_q ? StPause : StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPause: begin
        if (membus.wr_rs[port_q]) begin
          cmb_d   = cmb_q | membus.mb_in[32'(port_q)*36 +: 36];
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (cnt_q == CW'(T_WRITE - 1)) begin
          wr_en   = 1'b1;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecover: state_d = sw_single_step ? StStop : StIdle;
      StStop:    if (sw_restart && !restart_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= PW'(NPORT - 1);
      port_q    <= '0;
      cma_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cmb_q     <= '0;
      cnt_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      port_q    <= port_d;
      cma_q     <= cma_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cmb_q     <= cmb_d;
      cnt_q     <= cnt_d;
      restart_q <= sw_restart;
    end
  end

`ifdef CORE_PARITY_EN
  assign wdata      = {~^cmb_q, cmb_q};
  assign parity_err = strobe & ~(^rdata_q);
`else
  assign wdata = cmb_q;
`endif

  // cma is stable from the grant onward, so a registered read is ready by the strobe.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[cma_q] <= wdata;
    rdata_q <= mem[cma_q];
  end

  always_comb begin
    membus.addr_ack = '0;
    membus.rd_rs    = '0;
    membus.mb_out   = '0;
    if (state_q == StAck) membus.addr_ack[port_q] = 1'b1;
    if (strobe && rd_q) begin
      membus.rd_rs[port_q]                  = 1'b1;
      membus.mb_out[32'(port_q)*36 +: 36] = rdata_q[35:0];
    end
  end

  assign stopped = (state_q == StStop);
  assign busy    = (state_q != StIdle) && (state_q != StStop);
endmodule
